// File: rtl/mem_arbiter_if.sv
// Bundle for the arbiter: instruction/data requester ports, pipeline freeze,
// and the shared single-port memory bus.
interface mem_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_stall;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic [31:0] data_rdata;
    logic        data_stall;

    logic        longest_stall;

    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    // master: the arbiter, which masters the shared memory bus
    modport master (
        input  inst_req, inst_addr,
        output inst_rdata, inst_stall,
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_rdata, data_stall,
        input  longest_stall,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    // slave: the surrounding pipeline stages and the memory
    modport slave (
        output inst_req, inst_addr,
        input  inst_rdata, inst_stall,
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_rdata, data_stall,
        output longest_stall,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one memory bus with a
// single outstanding transaction; done flags stop re-issue while the pipeline is frozen.
module mem_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master io_arb
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_I_ADDR,
        S_I_DATA,
        S_D_ADDR,
        S_D_DATA
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_inst_done;
    logic        r_data_done;
    logic [31:0] r_inst_buf;
    logic [31:0] r_data_buf;

    logic        r_bus_wr;
    logic [1:0]  r_bus_size;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_wstrb;

    logic        w_inst_pend;
    logic        w_data_pend;
    logic        w_pick_inst;
    logic        w_pick_data;
    logic        w_inst_complete;
    logic        w_data_complete;

    assign w_inst_pend = io_arb.inst_req & ~r_inst_done;
    assign w_data_pend = io_arb.data_req & ~r_data_done;

    // Data wins a tie only when DATA_FIRST is set; otherwise it waits for inst.
    assign w_pick_data = w_data_pend & (DATA_FIRST | ~w_inst_pend);
    assign w_pick_inst = w_inst_pend & ~w_pick_data;

    assign w_inst_complete = (r_state == S_I_DATA) & io_arb.bus_data_ok;
    assign w_data_complete = (r_state == S_D_DATA) & io_arb.bus_data_ok;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_pick_data) begin
                    w_next_state = S_D_ADDR;
                end else if (w_pick_inst) begin
                    w_next_state = S_I_ADDR;
                end
            end
            S_I_ADDR: if (io_arb.bus_addr_ok) w_next_state = S_I_DATA;
            S_I_DATA: if (io_arb.bus_data_ok) w_next_state = S_IDLE;
            S_D_ADDR: if (io_arb.bus_addr_ok) w_next_state = S_D_DATA;
            S_D_DATA: if (io_arb.bus_data_ok) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bus attributes are frozen at issue so the bus never sees requester changes mid-transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_wr    <= 1'b0;
            r_bus_size  <= 2'd0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_wstrb <= 4'd0;
        end else if (r_state == S_IDLE) begin
            if (w_pick_data) begin
                r_bus_wr    <= io_arb.data_wr;
                r_bus_size  <= io_arb.data_size;
                r_bus_addr  <= io_arb.data_addr;
                r_bus_wdata <= io_arb.data_wdata;
                r_bus_wstrb <= io_arb.data_wstrb;
            end else if (w_pick_inst) begin
                r_bus_wr    <= 1'b0;
                r_bus_size  <= 2'd2;
                r_bus_addr  <= io_arb.inst_addr;
                r_bus_wdata <= 32'd0;
                r_bus_wstrb <= 4'd0;
            end
        end
    end

    // A completion on the same edge the pipeline advances keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
        end else begin
            if (w_inst_complete) begin
                r_inst_done <= 1'b1;
            end else if (!io_arb.longest_stall) begin
                r_inst_done <= 1'b0;
            end
            if (w_data_complete) begin
                r_data_done <= 1'b1;
            end else if (!io_arb.longest_stall) begin
                r_data_done <= 1'b0;
            end
        end
    end

    // NOTE: the response buffers are plain registers, so clearing them on reset is cheap and intended.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_buf <= 32'd0;
            r_data_buf <= 32'd0;
        end else begin
            if (w_inst_complete) r_inst_buf <= io_arb.bus_rdata;
            if (w_data_complete) r_data_buf <= io_arb.bus_rdata;
        end
    end

    assign io_arb.bus_req    = (r_state == S_I_ADDR) | (r_state == S_D_ADDR);
    assign io_arb.bus_wr     = r_bus_wr;
    assign io_arb.bus_size   = r_bus_size;
    assign io_arb.bus_addr   = r_bus_addr;
    assign io_arb.bus_wdata  = r_bus_wdata;
    assign io_arb.bus_wstrb  = r_bus_wstrb;

    assign io_arb.inst_stall = io_arb.inst_req & ~r_inst_done;
    assign io_arb.data_stall = io_arb.data_req & ~r_data_done;
    assign io_arb.inst_rdata = r_inst_buf;
    assign io_arb.data_rdata = r_data_buf;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a bus slave with programmable wait states,
// a scoreboard of expected bus transactions, and one task per scenario.
module tb_mem_arbiter;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic r_freeze = 1'b0;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   addr_wait = 0;
    int   data_wait = 0;
    bit   s_busy = 1'b0;
    logic [31:0] s_addr;
    txn_t sb_q[$];

    mem_arbiter_if ifc();

    mem_arbiter #(.DATA_FIRST(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_arb (ifc)
    );

    always #5 clk = ~clk;

    assign ifc.longest_stall = ifc.inst_stall | ifc.data_stall | r_freeze;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h3C08_0001 : (a ^ 32'hA5A5_5A5A);
    endfunction

    function automatic txn_t mk_inst(input logic [31:0] a);
        return '{wr: 1'b0, size: 2'd2, addr: a, wdata: 32'd0, wstrb: 4'd0};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory slave: addr_ok after addr_wait cycles of bus_req, data_ok data_wait cycles later.
    initial begin : slave
        int cnt;
        cnt = 0;
        ifc.bus_addr_ok = 1'b0;
        ifc.bus_data_ok = 1'b0;
        ifc.bus_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            ifc.bus_addr_ok = 1'b0;
            ifc.bus_data_ok = 1'b0;
            if (!s_busy) begin
                if (ifc.bus_req) begin
                    if (cnt >= addr_wait) begin
                        ifc.bus_addr_ok = 1'b1;
                        s_addr = ifc.bus_addr;
                        s_busy = 1'b1;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end else if (cnt >= data_wait) begin
                ifc.bus_data_ok = 1'b1;
                ifc.bus_rdata   = mem_model(s_addr);
                s_busy = 1'b0;
                cnt = 0;
            end else begin
                cnt++;
            end
        end
    end

    // Bus monitor: pops the scoreboard on each accepted request, checks overlap and length.
    initial begin : monitor
        bit   out_f;
        bit   abandoned;
        int   len;
        txn_t got;
        txn_t exp_t;
        out_f = 1'b0;
        abandoned = 1'b0;
        len = 0;
        forever begin
            tick();
            if (!rst && out_f) abandoned = 1'b1;
            if (ifc.bus_req) begin
                if (out_f) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL bus_overlap: got bus_req=1 with a transaction outstanding, want bus_req=0");
                end
                len++;
                if (ifc.bus_addr_ok) begin
                    got = '{wr: ifc.bus_wr, size: ifc.bus_size, addr: ifc.bus_addr,
                            wdata: ifc.bus_wdata, wstrb: ifc.bus_wstrb};
                    n_tests++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL bus_unexpected: got request addr=%h, want no request", got.addr);
                    end else begin
                        exp_t = sb_q.pop_front();
                        if (got.wr !== exp_t.wr || got.size !== exp_t.size || got.addr !== exp_t.addr ||
                            got.wstrb !== exp_t.wstrb || (exp_t.wr && got.wdata !== exp_t.wdata)) begin
                            n_fail++;
                            $display("FAIL bus_attr: got wr=%b size=%0d addr=%h wdata=%h wstrb=%h, want wr=%b size=%0d addr=%h wdata=%h wstrb=%h",
                                     got.wr, got.size, got.addr, got.wdata, got.wstrb,
                                     exp_t.wr, exp_t.size, exp_t.addr, exp_t.wdata, exp_t.wstrb);
                        end
                    end
                    out_f = 1'b1;
                end
            end else if (out_f) begin
                len++;
                if (ifc.bus_data_ok) begin
                    if (!abandoned) begin
                        n_tests++;
                        if (len != addr_wait + data_wait + 2) begin
                            n_fail++;
                            $display("FAIL bus_txn_len: got %0d cycles, want %0d", len, addr_wait + data_wait + 2);
                        end
                    end
                    out_f = 1'b0;
                    abandoned = 1'b0;
                    len = 0;
                end
            end
        end
    end

    task automatic test_reset();
        ifc.inst_req = 1'b0;   ifc.inst_addr = 32'd0;
        ifc.data_req = 1'b0;   ifc.data_wr = 1'b0;  ifc.data_size = 2'd0;
        ifc.data_addr = 32'd0; ifc.data_wdata = 32'd0; ifc.data_wstrb = 4'd0;
        rst = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (ifc.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b, want 0", ifc.bus_req); end
        n_tests++;
        if (ifc.inst_rdata !== 32'd0 || ifc.data_rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_rdata: got inst=%h data=%h, want 0/0", ifc.inst_rdata, ifc.data_rdata);
        end
        n_tests++;
        if (ifc.bus_addr !== 32'd0 || ifc.bus_wr !== 1'b0 || ifc.bus_size !== 2'd0 || ifc.bus_wstrb !== 4'd0) begin
            n_fail++; $display("FAIL reset_attr: got addr=%h wr=%b size=%0d wstrb=%h, want all 0",
                               ifc.bus_addr, ifc.bus_wr, ifc.bus_size, ifc.bus_wstrb);
        end
        ifc.data_req = 1'b1;
        #1;
        n_tests++;
        if (ifc.data_stall !== 1'b1) begin n_fail++; $display("FAIL reset_done_clear: got data_stall=%b, want 1", ifc.data_stall); end
        ifc.data_req = 1'b0;
        #1;
        n_tests++;
        if (ifc.data_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle: got data_stall=%b, want 0", ifc.data_stall); end
    endtask

    task automatic test_inst_fetch();
        bit started;
        bit done;
        int cnt;
        started = 1'b0; done = 1'b0; cnt = 0;
        addr_wait = 0; data_wait = 1;
        sb_q.push_back(mk_inst(32'hBFC0_0000));
        ifc.inst_req = 1'b1;
        ifc.inst_addr = 32'hBFC0_0000;
        rst = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (ifc.bus_req && !started) begin
                started = 1'b1;
                n_tests++;
                if (i != 0) begin n_fail++; $display("FAIL first_issue: got bus_req at cycle %0d after release, want 0", i); end
            end
            if (started) begin
                if (ifc.inst_stall) cnt++;
                else done = 1'b1;
            end
        end
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL inst_timeout: got no completion, want completion within 20 cycles"); end
        n_tests++;
        if (cnt != 3) begin n_fail++; $display("FAIL inst_stall_len: got %0d cycles, want 3", cnt); end
        n_tests++;
        if (ifc.inst_rdata !== 32'h3C08_0001) begin n_fail++; $display("FAIL inst_rdata: got %h, want 3c080001", ifc.inst_rdata); end
        ifc.inst_req = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (ifc.inst_rdata !== 32'h3C08_0001 || ifc.bus_req !== 1'b0) begin
            n_fail++; $display("FAIL inst_hold: got rdata=%h bus_req=%b, want 3c080001/0", ifc.inst_rdata, ifc.bus_req);
        end
    endtask

    task automatic test_priority();
        int d_at;
        int i_at;
        bit order_bad;
        bit both_stalled;
        d_at = -1; i_at = -1; order_bad = 1'b0; both_stalled = 1'b0;
        addr_wait = 1; data_wait = 1;
        sb_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h8000_1000, wdata: 32'd0, wstrb: 4'd0});
        sb_q.push_back(mk_inst(32'hBFC0_0010));
        ifc.data_req = 1'b1; ifc.data_wr = 1'b0; ifc.data_size = 2'd2;
        ifc.data_addr = 32'h8000_1000; ifc.data_wdata = 32'd0; ifc.data_wstrb = 4'd0;
        ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC0_0010;
        for (int i = 0; i < 40 && i_at < 0; i++) begin
            tick();
            if (i == 0) both_stalled = ifc.inst_stall & ifc.data_stall;
            if (ifc.bus_req && ifc.bus_addr == 32'hBFC0_0010 && ifc.data_stall) order_bad = 1'b1;
            if (d_at >= 0 && ifc.data_stall) order_bad = 1'b1;
            if (d_at < 0 && !ifc.data_stall) d_at = i;
            if (i_at < 0 && !ifc.inst_stall) i_at = i;
        end
        n_tests++;
        if (!both_stalled) begin n_fail++; $display("FAIL prio_initial_stall: got both_stalled=0, want 1"); end
        n_tests++;
        if (i_at < 0 || d_at < 0 || d_at >= i_at) begin
            n_fail++; $display("FAIL prio_order: got data_done=%0d inst_done=%0d, want data strictly first", d_at, i_at);
        end
        n_tests++;
        if (order_bad) begin n_fail++; $display("FAIL prio_overlap: got inst issued before data done or data re-stalled, want neither"); end
        n_tests++;
        if (ifc.data_rdata !== mem_model(32'h8000_1000) || ifc.inst_rdata !== mem_model(32'hBFC0_0010)) begin
            n_fail++; $display("FAIL prio_rdata: got data=%h inst=%h, want %h/%h", ifc.data_rdata, ifc.inst_rdata,
                               mem_model(32'h8000_1000), mem_model(32'hBFC0_0010));
        end
        ifc.data_req = 1'b0;
        ifc.inst_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_store_byte();
        bit prev_ok;
        bit done;
        bit seen_req;
        prev_ok = 1'b0; done = 1'b0; seen_req = 1'b0;
        addr_wait = 0; data_wait = 0;
        sb_q.push_back('{wr: 1'b1, size: 2'd0, addr: 32'h8000_0001, wdata: 32'h0000_AB00, wstrb: 4'h2});
        ifc.data_req = 1'b1; ifc.data_wr = 1'b1; ifc.data_size = 2'd0;
        ifc.data_addr = 32'h8000_0001; ifc.data_wdata = 32'h0000_AB00; ifc.data_wstrb = 4'h2;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (ifc.bus_req && !seen_req) begin
                seen_req = 1'b1;
                n_tests++;
                if (ifc.bus_wr !== 1'b1 || ifc.bus_size !== 2'd0 || ifc.bus_wstrb !== 4'h2 || ifc.bus_wdata !== 32'h0000_AB00) begin
                    n_fail++; $display("FAIL store_attr: got wr=%b size=%0d wstrb=%h wdata=%h, want 1/0/2/0000ab00",
                                       ifc.bus_wr, ifc.bus_size, ifc.bus_wstrb, ifc.bus_wdata);
                end
            end
            if (prev_ok) begin
                n_tests++;
                if (ifc.data_stall !== 1'b0) begin n_fail++; $display("FAIL store_stall_drop: got %b, want 0", ifc.data_stall); end
                done = 1'b1;
            end else if (ifc.bus_data_ok) begin
                n_tests++;
                if (ifc.data_stall !== 1'b1) begin n_fail++; $display("FAIL store_stall_hold: got %b, want 1", ifc.data_stall); end
                prev_ok = 1'b1;
            end
        end
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL store_timeout: got no data_ok, want one within 20 cycles"); end
        ifc.data_req = 1'b0; ifc.data_wr = 1'b0; ifc.data_wstrb = 4'h0;
        repeat (2) tick();
    endtask

    task automatic test_frozen();
        bit done;
        bit bad;
        logic [31:0] hold;
        done = 1'b0; bad = 1'b0;
        addr_wait = 0; data_wait = 0;
        r_freeze = 1'b1;
        sb_q.push_back(mk_inst(32'hBFC0_0020));
        ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC0_0020;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (!ifc.inst_stall) done = 1'b1;
        end
        hold = ifc.inst_rdata;
        n_tests++;
        if (!done || hold !== mem_model(32'hBFC0_0020)) begin
            n_fail++; $display("FAIL frozen_fetch: got done=%b rdata=%h, want 1/%h", done, hold, mem_model(32'hBFC0_0020));
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ifc.bus_req || ifc.inst_stall || ifc.inst_rdata !== hold) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL frozen_reissue: got re-issue, stall or rdata change, want none"); end
        r_freeze = 1'b0;
        tick();
        n_tests++;
        if (ifc.inst_stall !== 1'b1) begin n_fail++; $display("FAIL frozen_flag_clear: got inst_stall=%b, want 1", ifc.inst_stall); end
        ifc.inst_req = 1'b0;
        tick();
        n_tests++;
        if (ifc.bus_req !== 1'b0) begin n_fail++; $display("FAIL frozen_no_issue: got bus_req=%b, want 0", ifc.bus_req); end
    endtask

    task automatic test_reset_mid();
        bit accepted;
        accepted = 1'b0;
        addr_wait = 0; data_wait = 5;
        sb_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h8000_2000, wdata: 32'd0, wstrb: 4'd0});
        ifc.data_req = 1'b1; ifc.data_wr = 1'b0; ifc.data_size = 2'd2;
        ifc.data_addr = 32'h8000_2000; ifc.data_wstrb = 4'd0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            tick();
            if (ifc.bus_addr_ok) accepted = 1'b1;
        end
        n_tests++;
        if (!accepted) begin n_fail++; $display("FAIL rmid_timeout: got no addr_ok, want one within 20 cycles"); end
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (ifc.bus_req !== 1'b0 || ifc.data_rdata !== 32'd0 || ifc.bus_addr !== 32'd0) begin
            n_fail++; $display("FAIL rmid_reset: got bus_req=%b rdata=%h addr=%h, want 0/0/0", ifc.bus_req, ifc.data_rdata, ifc.bus_addr);
        end
        ifc.data_req = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 20 && s_busy; i++) tick();
        n_tests++;
        if (s_busy) begin n_fail++; $display("FAIL rmid_slave: got slave still busy, want late data_ok delivered"); end
        repeat (2) tick();
        n_tests++;
        if (ifc.data_rdata !== 32'd0 || ifc.bus_req !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ignored: got rdata=%h bus_req=%b, want 0/0", ifc.data_rdata, ifc.bus_req);
        end
        ifc.data_req = 1'b1;
        #1;
        n_tests++;
        if (ifc.data_stall !== 1'b1) begin n_fail++; $display("FAIL rmid_no_flag: got data_stall=%b, want 1", ifc.data_stall); end
        ifc.data_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        int k;
        logic [31:0] base;
        k = 0;
        base = 32'hBFC0_0100;
        addr_wait = 0; data_wait = 0;
        for (int j = 0; j < 4; j++) sb_q.push_back(mk_inst(base + 32'(4 * j)));
        ifc.inst_req = 1'b1; ifc.inst_addr = base;
        for (int i = 0; i < 60 && k < 4; i++) begin
            tick();
            if (!ifc.inst_stall) begin
                n_tests++;
                if (ifc.inst_rdata !== mem_model(base + 32'(4 * k))) begin
                    n_fail++; $display("FAIL burst_rdata%0d: got %h, want %h", k, ifc.inst_rdata, mem_model(base + 32'(4 * k)));
                end
                k++;
                if (k == 4) ifc.inst_req = 1'b0;
                else ifc.inst_addr = base + 32'(4 * k);
            end
        end
        n_tests++;
        if (k != 4) begin n_fail++; $display("FAIL burst_timeout: got %0d fetches, want 4", k); end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_inst_fetch();
        test_priority();
        test_store_byte();
        test_frozen();
        test_reset_mid();
        test_back_to_back();
        n_tests++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending, want 0", sb_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_FIRST, default 1: when 1, a pending data request wins over a simultaneous instruction request; when 0, instruction wins.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 inst_req  input  1  fetch stage requests a 32-bit read at inst_addr.
REQ-005 inst_addr  input  32  fetch address; stable while inst_req=1 and inst_stall=1.
REQ-006 inst_rdata  output  32  fetched word; valid when inst_req=1 and inst_stall=0.
REQ-007 inst_stall  output  1  to hazard unit as stall_from_if.
REQ-008 data_req  input  1  mem stage access request (mem_enM).
REQ-009 data_wr  input  1  1 = write, 0 = read.
REQ-010 data_size  input  2  0 byte, 1 half, 2 word.
REQ-011 data_addr, data_wdata  input  32 each  access address / store data.
REQ-012 data_wstrb  input  4  byte enables for writes.
REQ-013 data_rdata  output  32  load data; valid when data_req=1 and data_stall=0.
REQ-014 data_stall  output  1  to hazard unit as stall_from_mem.
REQ-015 longest_stall  input  1  pipeline frozen; 1 while any stage stalls.
REQ-016 bus_req  output  1  shared memory port request.
REQ-017 bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb  output  1/2/32/32/4  request attributes.
REQ-018 bus_addr_ok  input  1  request accepted this cycle when bus_req=1.
REQ-019 bus_data_ok  input  1  response (read data or write ack) this cycle.
REQ-020 bus_rdata  input  32  read data, valid with bus_data_ok.

Function
REQ-021 FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA; exactly one bus transaction outstanding at any time.
REQ-022 IDLE: select requester whose req=1 and done flag=0; tie broken by DATA_FIRST; go to I_ADDR or D_ADDR same edge; stay IDLE if none.
REQ-023 x_ADDR: bus_req=1 with the selected requester's attributes (instruction: bus_wr=0, bus_size=2, bus_wstrb=0); on bus_addr_ok=1 go to x_DATA; bus_req=0 in all other states.
REQ-024 x_DATA: wait for bus_data_ok; on it latch bus_rdata into the requester's buffer, set its done flag, return to IDLE.
REQ-025 Attributes are captured into internal registers on IDLE->x_ADDR; bus outputs drive from those registers, never combinationally from requester inputs.
REQ-026 inst_stall = inst_req & ~inst_done; data_stall = data_req & ~data_done (combinational).
REQ-027 inst_rdata / data_rdata driven from the latched buffers; buffers hold value until next completion.
REQ-028 Done flags clear on the edge where longest_stall=0 (pipeline advances); a flag set on the same edge as longest_stall=0 is still set (set wins).
REQ-029 A completed requester is not re-issued while its done flag=1, so a frozen pipeline never triggers a duplicate access.
REQ-030 Requests withdrawn (req=0) after issue are still completed on the bus; result is latched and the flag cleared by REQ-028 without effect.
REQ-031 Back-to-back: earliest issue of a new transaction is the edge after the previous bus_data_ok; minimum transaction is 2 cycles (addr_ok in first, data_ok in second).
REQ-032 bus_addr_ok or bus_data_ok arriving in a state not expecting it is ignored.

Reset
REQ-033 rst=0 forces immediately: state IDLE, done flags 0, buffers 0, captured attributes 0, bus_req=0.
REQ-034 Reset mid-transaction abandons it; no response is latched after release.
REQ-035 First issue possible on the first rising edge with rst=1.

Verification
REQ-036 Inst only, addr 0xBFC00000, addr_ok cycle 1, data_ok cycle 3 rdata 0x3C080001 -> inst_stall 1 for 3 cycles, then 0 with inst_rdata=0x3C080001.
REQ-037 inst_req and data_req (read, addr 0x80001000) same cycle, DATA_FIRST=1 -> data issued first; inst bus_req only after data bus_data_ok; both stalls held until each done.
REQ-038 Store byte data_wstrb=0x2 addr 0x80000001 -> bus_wr=1, bus_size=0, bus_wstrb=0x2, bus_wdata equal to data_wdata; data_stall drops the cycle after data_ok.
REQ-039 Inst done while longest_stall=1 for 5 cycles -> no second instruction bus_req; inst_rdata stable; flag clears when longest_stall=0.
REQ-040 rst asserted in D_DATA, then bus_data_ok pulses -> state IDLE, data_rdata=0, no flag set.
REQ-041 Burst of 4 fetches with 0-wait slave -> one transaction per 2 cycles, no overlap of bus_req with outstanding transaction.
